sort4_seq: RTL

SORT4_SEQ -- requirements
Module: sort4_seq

---
 rtl/sort4_seq_if.sv | 23 ++
 rtl/sort4_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/sort4_seq_if.sv
// Handshake bus for sort4_seq: a load stream in and a sorted drain stream out.
// The master drives in_valid/in_data/out_ready; the slave (the sorter) drives the rest.
interface sort4_seq_if #(
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort4_seq.sv
// Sequential 4-element sorter: loads four unsigned words, sorts them with six
// compare-exchange steps (one per cycle), then drains them in ascending order.
module sort4_seq #(
    parameter int unsigned W = 4
) (
    input  logic        clk,
    input  logic        rst,
    sort4_seq_if.slave  bus,
    output logic        busy
);
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned SW = 3;
    localparam logic [SW-1:0] LAST_STEP = SW'(5);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [SW-1:0]   r_step;
    logic [W-1:0]    r_v [N];
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_busy;
    logic [W-1:0]    r_out_data;

    logic [IW-1:0]   w_i;
    logic [IW-1:0]   w_j;
    logic            w_swap;

    // Pair selected by the current sort step: (0,1)(0,2)(0,3)(1,2)(1,3)(2,3)
    always_comb begin
        w_i = IW'(0);
        w_j = IW'(1);
        case (r_step)
            SW'(0):  begin w_i = IW'(0); w_j = IW'(1); end
            SW'(1):  begin w_i = IW'(0); w_j = IW'(2); end
            SW'(2):  begin w_i = IW'(0); w_j = IW'(3); end
            SW'(3):  begin w_i = IW'(1); w_j = IW'(2); end
            SW'(4):  begin w_i = IW'(1); w_j = IW'(3); end
            default: begin w_i = IW'(2); w_j = IW'(3); end
        endcase
        w_swap = (r_v[w_i] > r_v[w_j]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_step      <= '0;
            r_v         <= '{default: '0};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (bus.in_valid) begin
                        r_v[r_cnt] <= bus.in_data;
                        r_cnt      <= r_cnt + IW'(1);
                        if (r_cnt == IW'(3)) begin
                            r_state    <= SORT;
                            r_step     <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (w_swap) begin
                        r_v[w_i] <= r_v[w_j];
                        r_v[w_j] <= r_v[w_i];
                    end
                    r_step <= r_step + SW'(1);
                    // The final step only touches slots 2 and 3, so slot 0 is already settled
                    if (r_step == LAST_STEP) begin
                        r_state     <= DRAIN;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_v[0];
                        r_out_last  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (r_idx == IW'(3)) begin
                            r_state     <= LOAD;
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx      <= r_idx + IW'(1);
                            r_out_data <= r_v[r_idx + IW'(1)];
                            r_out_last <= (r_idx == IW'(2));
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;
endmodule
